// File: rtl/sram_burst_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : sram_burst_ctrl_if
//  Description : Bundles the command, write-beat and read-beat handshakes
//                of the burst SRAM endpoint.
//                master modport : the requester (CPU / DMA side)
//                slave  modport : the memory endpoint (sram_burst_ctrl)
//  Signals     : cmd_valid/cmd_ready/cmd_we/cmd_addr/cmd_len  burst command
//                wr_valid/wr_ready/wr_data/wr_be              write beats
//                rd_valid/rd_ready/rd_data                    read beats
//                busy                                         burst active
//  Revision    : 1.0  initial release
// ============================================================================
interface sram_burst_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11,
    parameter int LEN_W  = 4
) ();
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_we;
    logic [ADDR_W-1:0]     cmd_addr;
    logic [LEN_W-1:0]      cmd_len;

    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_W-1:0]     wr_data;
    logic [DATA_W/8-1:0]   wr_be;

    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_W-1:0]     rd_data;

    logic                  busy;

    modport master (
        output cmd_valid, cmd_we, cmd_addr, cmd_len,
        output wr_valid, wr_data, wr_be,
        output rd_ready,
        input  cmd_ready, wr_ready, rd_valid, rd_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_we, cmd_addr, cmd_len,
        input  wr_valid, wr_data, wr_be,
        input  rd_ready,
        output cmd_ready, wr_ready, rd_valid, rd_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/sram_burst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sram_burst_ctrl
//  Description : Single-port synchronous SRAM with integrated address (MAR)
//                and data (MDR) registers behind a valid/ready burst
//                interface. Bursts are incrementing, length cmd_len+1 beats,
//                with address wrap modulo the array depth. Writes accept one
//                beat per cycle with byte-lane enables; reads return one
//                beat every two cycles through MDR.
//  Ports       : clock  - rising-edge clock
//                reset  - asynchronous active-high reset of control state
//                bus    - sram_burst_ctrl_if.slave (command / write / read
//                         handshakes and busy)
//  Revision    : 1.0  initial release
// ============================================================================
module sram_burst_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11,
    parameter int LEN_W  = 4
) (
    input  wire              clock,
    input  wire              reset,
    sram_burst_ctrl_if.slave bus
);

    localparam int                c_lanes    = DATA_W / 8;
    localparam int                c_depth    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);
    localparam logic [LEN_W-1:0]  c_len_one  = LEN_W'(1);
    localparam logic [LEN_W-1:0]  c_len_zero = '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_mar;
    logic [ADDR_W-1:0]  w_mar_nxt;
    logic [LEN_W-1:0]   r_cnt;
    logic [LEN_W-1:0]   w_cnt_nxt;
    logic [DATA_W-1:0]  r_mdr;

    // Storage array: not reset, contents undefined at power-up.
    logic [DATA_W-1:0]  r_mem [c_depth];

    logic w_cmd_fire;
    logic w_wr_fire;
    logic w_rd_fire;
    logic w_last;

    assign w_cmd_fire = (r_state == S_IDLE)  && bus.cmd_valid;
    assign w_wr_fire  = (r_state == S_WRITE) && bus.wr_valid;
    assign w_rd_fire  = (r_state == S_RESP)  && bus.rd_ready;
    assign w_last     = (r_cnt == c_len_zero);

    // cmd_ready is masked by reset directly so no command can slip in while
    // reset is held; it rises as soon as reset is released.
    assign bus.cmd_ready = (r_state == S_IDLE) && !reset;
    assign bus.wr_ready  = (r_state == S_WRITE);
    assign bus.rd_valid  = (r_state == S_RESP);
    assign bus.rd_data   = r_mdr;
    assign bus.busy      = (r_state != S_IDLE);

    // ------------------------------------------------------------------
    // Next-state / MAR / CNT logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_mar_nxt   = r_mar;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_cmd_fire) begin
                    w_mar_nxt   = bus.cmd_addr;
                    w_cnt_nxt   = bus.cmd_len;
                    w_state_nxt = bus.cmd_we ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                if (w_wr_fire) begin
                    if (w_last) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        // Natural overflow of the MAR gives the modulo wrap.
                        w_mar_nxt = r_mar + c_addr_one;
                        w_cnt_nxt = r_cnt - c_len_one;
                    end
                end
            end
            S_READ: begin
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (w_rd_fire) begin
                    if (w_last) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_mar_nxt   = r_mar + c_addr_one;
                        w_cnt_nxt   = r_cnt - c_len_one;
                        w_state_nxt = S_READ;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control registers and MDR
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_mar   <= '0;
            r_cnt   <= '0;
            r_mdr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mar   <= w_mar_nxt;
            r_cnt   <= w_cnt_nxt;
            // MDR only loads in READ so rd_data is frozen through RESP.
            if (r_state == S_READ) begin
                r_mdr <= r_mem[r_mar];
            end
        end
    end

    // ------------------------------------------------------------------
    // Array write port with per-byte lane enables. Reset forces IDLE, so
    // no write can happen while reset is asserted.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (w_wr_fire) begin
            for (int i = 0; i < c_lanes; i++) begin
                if (bus.wr_be[i]) begin
                    r_mem[r_mar][i*8 +: 8] <= bus.wr_data[i*8 +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_burst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_burst_ctrl
//  Description : Self-checking bench for sram_burst_ctrl. A word-array model
//                of the memory is updated on every accepted write beat; read
//                commands snapshot their expected beats from it into a queue
//                that a single compare process drains on each read handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sram_burst_ctrl;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 11;
    localparam int LEN_W  = 4;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int LANES  = DATA_W / 8;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    sram_burst_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

    sram_burst_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] m_mem [DEPTH];
    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] last_rd [$];
    bit                hold_cmd = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_write(input int a, input logic [DATA_W-1:0] d,
                                        input logic [LANES-1:0] be);
        logic [ADDR_W-1:0] ai;
        ai = a[ADDR_W-1:0];
        for (int i = 0; i < LANES; i++) begin
            if (be[i]) m_mem[ai][i*8 +: 8] = d[i*8 +: 8];
        end
    endfunction

    // ------------------------------------------------------------------
    // Compare process: reset values, protocol invariants, read data.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] hold_data;
    bit                hold_valid = 1'b0;

    always @(negedge clock) begin
        if (reset) begin
            chk("rst_cmd_ready", 32'(bus.cmd_ready), 0);
            chk("rst_busy",      32'(bus.busy),      0);
            chk("rst_wr_ready",  32'(bus.wr_ready),  0);
            chk("rst_rd_valid",  32'(bus.rd_valid),  0);
            chk("rst_rd_data",   32'(bus.rd_data),   0);
            hold_valid = 1'b0;
        end else begin
            chk("cmd_ready_vs_busy", 32'(bus.cmd_ready), 32'(!bus.busy));
            chk("wr_rd_exclusive", 32'(bus.wr_ready & bus.rd_valid), 0);
            if (hold_valid && bus.rd_valid)
                chk("rd_data_stable", 32'(bus.rd_data), 32'(hold_data));
            if (bus.rd_valid && bus.rd_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rd_unexpected_beat", exp_q.size(), 1);
                end else begin
                    chk("rd_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
                    last_rd.push_back(bus.rd_data);
                end
                hold_valid = 1'b0;
            end else if (bus.rd_valid) begin
                hold_valid = 1'b1;
                hold_data  = bus.rd_data;
            end else begin
                hold_valid = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks: entered and left at posedge+1.
    // ------------------------------------------------------------------
    task automatic wait_cmd(output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        forever begin
            @(negedge clock);
            if (bus.cmd_ready) ok = 1'b1;
            @(posedge clock); #1;
            if (ok) break;
            n++;
            if (n > 40) begin
                chk("cmd_accept_timeout", n, 40);
                break;
            end
        end
    endtask

    task automatic scramble_cmd();
        logic [31:0] r;
        r = $urandom;
        bus.cmd_addr = r[ADDR_W-1:0];
        bus.cmd_len  = r[ADDR_W +: LEN_W];
        bus.cmd_we   = r[31];
    endtask

    // mode 0: data = base+k, be = be_in; mode 1: random data, be = be_in;
    // mode 2: random data and random byte enables.
    task automatic do_write(input int addr, input int len, input int mode, input int base,
                            input logic [LANES-1:0] be_in, input int gap_pct,
                            input int abort_after, output int cyc);
        bit                 ok;
        int                 k;
        int                 t;
        logic [31:0]        r;
        logic [DATA_W-1:0]  d;
        logic [LANES-1:0]   be;
        cyc = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = 1'b1;
        bus.cmd_addr  = addr[ADDR_W-1:0];
        bus.cmd_len   = len[LEN_W-1:0];
        wait_cmd(ok);
        if (!ok) begin
            bus.cmd_valid = 1'b0;
            return;
        end
        if (hold_cmd) begin
            // Leave a read of the same range pending through the burst.
            bus.cmd_we = 1'b0;
        end else begin
            bus.cmd_valid = 1'b0;
            scramble_cmd();
        end
        k = 0;
        while (k <= len) begin
            r = $urandom;
            t = base + k;
            d  = (mode == 0) ? t[DATA_W-1:0] : r[DATA_W-1:0];
            be = (mode == 2) ? r[DATA_W +: LANES] : be_in;
            bus.wr_valid = ($urandom_range(99) >= gap_pct);
            bus.wr_data  = d;
            bus.wr_be    = be;
            @(negedge clock);
            cyc++;
            chk("wr_ready_in_burst", 32'(bus.wr_ready), 1);
            chk("busy_in_wr_burst",  32'(bus.busy),     1);
            if (bus.wr_valid && bus.wr_ready) begin
                model_write(addr + k, d, be);
                k++;
            end
            @(posedge clock); #1;
            if (cyc > 300) begin
                chk("wr_burst_timeout", cyc, 300);
                break;
            end
            if (abort_after > 0 && k == abort_after) begin
                bus.wr_valid = 1'b0;
                reset = 1'b1;
                repeat (2) @(posedge clock);
                #1;
                reset = 1'b0;
                @(negedge clock);
                chk("cmd_ready_after_release", 32'(bus.cmd_ready), 1);
                @(posedge clock); #1;
                return;
            end
        end
        bus.wr_valid = 1'b0;
        bus.wr_data  = DATA_W'($urandom);
        if (!hold_cmd) begin
            @(negedge clock);
            chk("busy_after_wr",      32'(bus.busy),      0);
            chk("cmd_ready_after_wr", 32'(bus.cmd_ready), 1);
            @(posedge clock); #1;
        end
    endtask

    // stall_max < 0 : every beat stalls exactly -stall_max cycles;
    // stall_max >= 0: random stall 0..stall_max per beat.
    task automatic do_read(input int addr, input int len, input int stall_max);
        bit                 ok;
        int                 lat;
        int                 stall;
        int                 t;
        logic [ADDR_W-1:0]  ai;
        for (int k = 0; k <= len; k++) begin
            t  = addr + k;
            ai = t[ADDR_W-1:0];
            exp_q.push_back(m_mem[ai]);
        end
        last_rd.delete();
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = 1'b0;
        bus.cmd_addr  = addr[ADDR_W-1:0];
        bus.cmd_len   = len[LEN_W-1:0];
        wait_cmd(ok);
        bus.cmd_valid = 1'b0;
        hold_cmd      = 1'b0;
        scramble_cmd();
        if (!ok) begin
            exp_q.delete();
            return;
        end
        for (int k = 0; k <= len; k++) begin
            stall = (stall_max < 0) ? -stall_max : int'($urandom_range(stall_max));
            bus.rd_ready = (stall == 0);
            lat = 0;
            forever begin
                @(negedge clock);
                if (bus.rd_valid || lat > 20) break;
                lat++;
                @(posedge clock); #1;
            end
            chk("rd_latency", lat, 1);
            if (lat > 20) begin
                @(posedge clock); #1;
                bus.rd_ready = 1'b0;
                exp_q.delete();
                return;
            end
            if (stall > 0) begin
                repeat (stall) begin
                    @(posedge clock); #1;
                    @(negedge clock);
                    chk("rd_valid_held_in_stall", 32'(bus.rd_valid), 1);
                end
                @(posedge clock); #1;
                bus.rd_ready = 1'b1;
                @(negedge clock);
            end
            @(posedge clock); #1;
            bus.rd_ready = 1'b0;
        end
        @(negedge clock);
        chk("busy_after_rd",      32'(bus.busy),      0);
        chk("cmd_ready_after_rd", 32'(bus.cmd_ready), 1);
        @(posedge clock); #1;
    endtask

    task automatic chk_rd(input string name, input int idx, input logic [DATA_W-1:0] exp);
        logic [DATA_W-1:0] v;
        v = (idx < last_rd.size()) ? last_rd[idx] : 'x;
        chk(name, 32'(v), 32'(exp));
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int          cyc;
        logic [31:0] r;
        bus.cmd_valid = 1'b0;
        bus.cmd_we    = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        bus.wr_be     = '0;
        bus.rd_ready  = 1'b0;
        #1 reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("cmd_ready_after_reset", 32'(bus.cmd_ready), 1);
        chk("busy_after_reset",      32'(bus.busy),      0);
        @(posedge clock); #1;

        // Give every location a defined value.
        for (int b = 0; b < DEPTH / 16; b++)
            do_write(b * 16, 15, 1, 0, '1, 0, 0, cyc);

        // Basic write burst then read-back.
        do_write('h010, 3, 0, 'hA000, 2'b11, 0, 0, cyc);
        chk("wr_burst4_cycles", cyc, 4);
        do_read('h010, 3, 0);
        chk("rd_beats", last_rd.size(), 4);
        chk_rd("lit_a000", 0, 16'hA000);
        chk_rd("lit_a001", 1, 16'hA001);
        chk_rd("lit_a002", 2, 16'hA002);
        chk_rd("lit_a003", 3, 16'hA003);

        // Byte-lane enables.
        do_write('h020, 0, 0, 'h1234, 2'b11, 0, 0, cyc);
        do_write('h020, 0, 0, 'hABCD, 2'b01, 0, 0, cyc);
        do_read('h020, 0, 0);
        chk_rd("lit_be01", 0, 16'h12CD);
        do_write('h020, 0, 0, 'hFFFF, 2'b00, 0, 0, cyc);
        do_read('h020, 0, 0);
        chk_rd("lit_be00", 0, 16'h12CD);

        // Address wrap.
        do_write('h7FE, 3, 0, 1, 2'b11, 0, 0, cyc);
        do_read('h7FE, 3, 0);
        chk_rd("lit_wrap0", 0, 16'd1);
        chk_rd("lit_wrap1", 1, 16'd2);
        chk_rd("lit_wrap2", 2, 16'd3);
        chk_rd("lit_wrap3", 3, 16'd4);

        // Backpressure on reads, gaps on writes.
        do_read('h010, 1, -5);
        chk_rd("lit_stall0", 0, 16'hA000);
        chk_rd("lit_stall1", 1, 16'hA001);
        do_write('h100, 7, 1, 0, 2'b11, 50, 0, cyc);
        do_read('h100, 7, 0);

        // Reset in the middle of a write burst.
        do_write('h200, 7, 0, 'hC000, 2'b11, 0, 3, cyc);
        do_read('h1FF, 9, 0);
        chk_rd("lit_abort_b0", 1, 16'hC000);
        chk_rd("lit_abort_b2", 3, 16'hC002);

        // Command held pending during a burst; maximum-length burst.
        hold_cmd = 1'b1;
        do_write('h300, 5, 1, 0, 2'b11, 20, 0, cyc);
        do_read('h300, 5, 1);
        do_write('h000, 15, 0, 'h5000, 2'b11, 0, 0, cyc);
        chk("wr_burst16_cycles", cyc, 16);
        do_read('h000, 15, 1);
        chk_rd("lit_max0",  0,  16'h5000);
        chk_rd("lit_max15", 15, 16'h500F);

        // Randomised traffic.
        for (int n = 0; n < 60; n++) begin
            r = $urandom;
            if (r[0])
                do_write(int'(r[1 +: ADDR_W]), int'(r[12 +: LEN_W]), 2, 0, '1,
                         int'($urandom_range(40)), 0, cyc);
            else
                do_read(int'(r[1 +: ADDR_W]), int'(r[12 +: LEN_W]), int'($urandom_range(3)));
        end

        // Full sweep catches any stray write anywhere in the array.
        for (int b = 0; b < DEPTH / 16; b++)
            do_read(b * 16, 15, 0);

        chk("exp_queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
